// File: rtl/njp_micro_mult_pkg.sv
// Shared types and pin-map constants for the njp_micro_mult TinyTapeout block.
// Holds the control FSM encoding, the uio bit positions and the operand/product widths.
package njp_micro_mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // uio bit positions: [3:0] are inputs, [6:4] are status outputs.
  localparam int LOAD_A = 0;
  localparam int LOAD_B = 1;
  localparam int START  = 2;
  localparam int SEL_HI = 3;
  localparam int BUSY   = 4;
  localparam int DONE   = 5;
  localparam int ZERO   = 6;

  localparam logic [7:0] UIO_OE = 8'hF0;

endpackage

// File: rtl/njp_mult_core.sv
// Shift-add datapath for an 8x8 unsigned multiply: working copies of the operands,
// the accumulator and the step counter. Sequencing is owned by the top-level FSM.
module njp_mult_core
  import njp_micro_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic              o_last,
  output logic [PROD_W-1:0] o_acc_next
);

  logic [PROD_W-1:0] r_a_sh;
  logic [OP_W-1:0]   r_b_sh;
  logic [PROD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  // The top captures o_acc_next into its result register on the last step, so the
  // final partial product is added in the same edge that finishes the operation.
  assign o_acc_next = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
  assign o_last     = (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of the order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_a_sh <= {{(PROD_W-OP_W){1'b0}}, i_a};
      r_b_sh <= i_b;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_acc  <= o_acc_next;
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/njp_micro_mult.sv
// TinyTapeout user block: byte-loaded 8x8 sequential multiplier with a byte-muxed
// 16-bit product on uo_out and busy/done/zero status on uio_out[6:4].
module njp_micro_mult
  import njp_micro_mult_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t            r_state;
  state_t            w_state_next;
  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  logic [PROD_W-1:0] r_result;
  logic              r_start_q;

  logic              w_io_ok;
  logic              w_load_any;
  logic              w_start_ok;
  logic              w_step;
  logic              w_last;
  logic              w_finish;
  logic [PROD_W-1:0] w_acc_next;
  logic              w_busy;
  logic              w_done;
  logic              w_zero;

  // Upper uio nibble is not part of the control interface.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, uio_in[7:4]};

  assign w_busy     = (r_state == ST_BUSY);
  assign w_done     = (r_state == ST_DONE);
  assign w_zero     = (r_result == '0);

  assign w_io_ok    = ena && !w_busy;
  assign w_load_any = w_io_ok && (uio_in[LOAD_A] || uio_in[LOAD_B]);
  assign w_start_ok = w_io_ok && uio_in[START] && !r_start_q;
  assign w_step     = ena && w_busy;
  assign w_finish   = w_step && w_last;

  njp_mult_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start_ok),
    .i_step     (w_step),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_last     (w_last),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every branch of a combinational block must assign its outputs; the default
  // assignment at the top guarantees that and keeps a latch from being inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_finish) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (w_start_ok)      w_state_next = ST_BUSY;
        else if (w_load_any) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // With ena low every register here holds, including the start edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_start_q <= 1'b0;
    end else if (ena) begin
      r_start_q <= uio_in[START];
      if (w_io_ok && uio_in[LOAD_A]) r_a <= ui_in;
      if (w_io_ok && uio_in[LOAD_B]) r_b <= ui_in;
      if (w_finish)                  r_result <= w_acc_next;
    end
  end

  assign uo_out = uio_in[SEL_HI] ? r_result[15:8] : r_result[7:0];

  always_comb begin
    uio_out       = 8'h00;
    uio_out[BUSY] = w_busy;
    uio_out[DONE] = w_done;
    uio_out[ZERO] = w_zero;
  end

  assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_njp_micro_mult.sv
// Self-checking bench for njp_micro_mult: a cycle-level behavioural model compared
// every cycle, plus literal expectations for products, latency, reset and status.
module tb_njp_micro_mult;

  localparam logic [3:0] C_LA = 4'b0001;
  localparam logic [3:0] C_LB = 4'b0010;
  localparam logic [3:0] C_ST = 4'b0100;
  localparam logic [3:0] C_HI = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b1;

  njp_micro_mult dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: operands, last product, a countdown for the multiply in flight.
  logic [7:0]  m_a, m_b;
  logic [15:0] m_result, m_pending;
  int          m_left;
  bit          m_busy, m_done, m_sq;

  always @(posedge clk or posedge rst) begin : model
    bit st, la, lb;
    if (rst) begin
      m_a = 0; m_b = 0; m_result = 0; m_pending = 0;
      m_left = 0; m_busy = 0; m_done = 0; m_sq = 0;
    end else if (ena) begin
      st = uio_in[2]; la = uio_in[0]; lb = uio_in[1];
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_result = m_pending;
          m_busy   = 0;
          m_done   = 1;
        end
      end else begin
        if (st && !m_sq) begin
          m_pending = 16'(m_a) * 16'(m_b);
          m_left    = 8;
          m_busy    = 1;
          m_done    = 0;
        end else if (la || lb) begin
          m_done = 0;
        end
        if (la) m_a = ui_in;
        if (lb) m_b = ui_in;
      end
      m_sq = st;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("uo_out", {8'h00, uo_out}, {8'h00, uio_in[3] ? m_result[15:8] : m_result[7:0]});
      check("uio_out", {8'h00, uio_out},
            {8'h00, 1'b0, (m_result == 16'h0), m_done, m_busy, 4'h0});
      check("uio_oe", {8'h00, uio_oe}, 16'h00F0);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [3:0] ctl);
    ui_in  = d;
    uio_in = {4'h0, ctl};
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    drive(a, C_LA); cyc();
    drive(b, C_LB); cyc();
    drive(8'h00, 4'h0);
  endtask

  // Waits for done with a bounded budget; k enters as cycles already spent.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (uio_out[5] !== 1'b1 && k < 40) begin
      cyc();
      k++;
    end
  endtask

  task automatic pulse_start();
    drive(8'h00, C_ST); cyc();
    drive(8'h00, 4'h0);
  endtask

  task automatic read_result(input string name, input logic [15:0] exp);
    uio_in[3] = 1'b0; #1;
    check({name, "_lo"}, {8'h00, uo_out}, {8'h00, exp[7:0]});
    uio_in[3] = 1'b1; #1;
    check({name, "_hi"}, {8'h00, uo_out}, {8'h00, exp[15:8]});
    uio_in[3] = 1'b0; #1;
    check({name, "_zero"}, {15'h0, uio_out[6]}, {15'h0, exp == 16'h0});
  endtask

  task automatic mult(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int k;
    load(a, b);
    pulse_start();
    check({name, "_busy"}, {15'h0, uio_out[4]}, 16'h0001);
    wait_done(0, k);
    check({name, "_latency"}, 16'(k), 16'd8);
    read_result(name, exp);
  endtask

  initial begin
    int k;
    repeat (3) cyc();
    check("rst_uo", {8'h00, uo_out}, 16'h0000);
    check("rst_status", {8'h00, uio_out}, 16'h0040);
    rst = 1'b0;
    cyc();

    mult("m13x11", 8'd13, 8'd11, 16'h008F);
    mult("m255x255", 8'd255, 8'd255, 16'hFE01);
    mult("m200x3", 8'd200, 8'd3, 16'h0258);
    mult("m0x77", 8'd0, 8'd77, 16'h0000);

    // Start and load_a during BUSY are both ignored.
    load(8'd7, 8'd9);
    pulse_start();
    cyc(); cyc();
    drive(8'h55, C_ST | C_LA); cyc();
    drive(8'h00, 4'h0);
    wait_done(3, k);
    check("busy_ign_latency", 16'(k), 16'd8);
    read_result("busy_ign", 16'h003F);
    pulse_start();
    wait_done(0, k);
    check("restart_latency", 16'(k), 16'd8);
    read_result("restart_a_kept", 16'h003F);

    // Start held high across completion: one multiply only, done stays up.
    drive(8'h00, C_ST);
    repeat (14) cyc();
    check("hold_status", {8'h00, uio_out}, 16'h0020);
    drive(8'h00, 4'h0); cyc();
    check("release_done", {15'h0, uio_out[5]}, 16'h0001);
    drive(8'd2, C_LA); cyc();
    check("load_clears_done", {15'h0, uio_out[5]}, 16'h0000);
    drive(8'd3, C_LB); cyc();
    drive(8'h00, 4'h0);
    pulse_start();
    wait_done(0, k);
    read_result("m2x3", 16'h0006);

    // ena low mid-multiply pauses the count for three cycles.
    load(8'd5, 8'd6);
    pulse_start();
    cyc(); cyc();
    ena = 1'b0;
    repeat (3) cyc();
    check("pause_busy", {15'h0, uio_out[4]}, 16'h0001);
    ena = 1'b1;
    wait_done(5, k);
    check("pause_latency", 16'(k), 16'd11);
    read_result("m5x6", 16'h001E);

    // Asynchronous reset during cycle 4 of a multiply.
    load(8'd100, 8'd100);
    pulse_start();
    cyc(); cyc(); cyc();
    rst = 1'b1; #1;
    check("abort_uo", {8'h00, uo_out}, 16'h0000);
    check("abort_status", {8'h00, uio_out}, 16'h0040);
    cyc();
    rst = 1'b0;
    cyc();
    mult("m12x12", 8'd12, 8'd12, 16'h0090);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/njp_micro_mult.md
Name: njp_micro_mult

Overview:
- Top-level TinyTapeout user block: 8x8 unsigned sequential shift-add multiplier driven over the standard TT pin set.
- Operands are loaded byte-wise through ui_in, a start strobe launches an 8-cycle multiply, and the 16-bit product is read back one byte at a time on uo_out.
- Status flags appear on the upper bidirectional pins.

Parameters:
- None. Operand width is fixed at 8 bits and product width at 16 bits by the pinout.

Ports:
- clk  in  1  system clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design enable; when low, load and start inputs are ignored and all state holds.
- ui_in  in  8  operand data bus.
- uio_in  in  8  control: [0] load_a, [1] load_b, [2] start, [3] sel_hi; [7:4] ignored.
- uo_out  out  8  product byte: sel_hi=0 gives result[7:0], sel_hi=1 gives result[15:8].
- uio_out  out  8  [3:0]=0, [4] busy, [5] done, [6] zero (result==0), [7]=0.
- uio_oe  out  8  constant 8'hF0: upper nibble output, lower nibble input.

Behaviour:
- Reset (async, rst=1): clear A, B, accumulator, result, counter, start_q, busy, done. Zero flag reads 1, since result==0. uo_out=0.
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- Loads, accepted only when ena=1 and not BUSY:
  - load_a=1 captures A<=ui_in at the clock edge; load_b=1 captures B<=ui_in.
  - Both high in the same cycle load the same byte into both operands.
  - Any accepted load in DONE clears done and returns to IDLE.
- Start:
  - Rising-edge detected: start_q is a register, and start is accepted when start & ~start_q & ena.
  - Accepted only in IDLE or DONE. Ignored in BUSY; holding start high does not retrigger.
  - On acceptance: clear accumulator, set counter=0, busy=1, done=0, enter BUSY.
- BUSY, at edges 1..8 after acceptance:
  - If B-shift[0]=1, accumulator += A-shift. The A copy shifts left (16-bit) and the B copy shifts right.
  - A and B themselves stay unchanged.
- On the 8th BUSY edge:
  - result <= final accumulator; busy=0; done=1; enter DONE.
  - Latency: start sampled at edge N gives result/done valid after edge N+8.
- result holds the last completed product. It is not updated mid-operation, so uo_out is stable while BUSY.
- done is sticky until the next accepted start or load.
- uo_out mux on sel_hi is purely combinational, with no added latency.
- ena low during BUSY: the multiply pauses (counter holds) and resumes when ena returns.
- Reset mid-operation aborts immediately: IDLE, result=0.
- Arithmetic is unsigned, and 16 bits never overflows (max 0xFE01).

Decomposition:
- Shared package: state enum (IDLE/BUSY/DONE), uio bit-index constants (LOAD_A=0, LOAD_B=1, START=2, SEL_HI=3, BUSY=4, DONE=5, ZERO=6), and constant UIO_OE=8'hF0.
- One natural sub-module, njp_mult_core: the shift-add datapath and counter, with the IO decode/mux kept in the top.

Test Plan:
- Load A=13, B=11, pulse start → busy for 8 cycles, then done=1, uo_out=0x8F (sel_hi=0), 0x00 (sel_hi=1), zero=0.
- A=255, B=255 → result 0xFE01: lo=0x01, hi=0xFE.
- A=200, B=3 → 0x0258. Then A=0, B=77 → 0x0000 with zero=1.
- Start A=7, B=9. During BUSY, pulse start again and load_a with 0x55 → both ignored; result=63 (0x3F) after exactly 8 cycles; A still 7 (re-start gives 63 again).
- Hold start high across completion → exactly one multiply. done stays 1 until start is released and re-pulsed or a load occurs.
- Assert rst at cycle 4 of a multiply → immediately busy=0, done=0, uo_out=0, zero=1. A fresh multiply afterwards is correct.
